fat32_volume_mount: RTL and testbench

Parametrised successor to the single-step FAT32 front end: on one `execute` it waits for SD-card initialisation, reads the MBR, selects a partition entry, reads that partition's volume boot record and publishes the FAT32 geometry the file-level logic needs. It sits between the file-access controller and `sd_card_controller`, owning the SD sector-read handshake for the whole mount sequence, and reports a pass/fail code.

---
 rtl/fat32_volume_mount_if.sv | 15 +
 rtl/fat32_volume_mount.sv | 190 +++++++++++++++++++
 tb/tb_fat32_volume_mount.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fat32_volume_mount_if.sv
// SD-controller sector-read handshake between the FAT32 mount front end and sd_card_controller.
interface fat32_volume_mount_if;
  logic        sd_init;
  logic        sd_rd_req;
  logic [31:0] sd_addr;
  logic [7:0]  sd_byte;
  logic        sd_byte_valid;
  logic        sd_block_done;
  logic        sd_busy;

  modport master (output sd_init, sd_rd_req, sd_addr,
                  input  sd_byte, sd_byte_valid, sd_block_done, sd_busy);
  modport slave  (input  sd_init, sd_rd_req, sd_addr,
                  output sd_byte, sd_byte_valid, sd_block_done, sd_busy);
endinterface

// File: rtl/fat32_volume_mount.sv
// FAT32 volume mount: SD init, MBR read, partition select, VBR read, geometry publish.
// State advances on the falling clock edge so the rising-edge SD controller sees stable requests.
module fat32_volume_mount #(
  parameter int PART_INDEX     = 0,
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 execute,
  fat32_volume_mount_if.master sd,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           err_code,
  output logic [31:0]          fat_begin_lba,
  output logic [31:0]          cluster_begin_lba,
  output logic [31:0]          root_cluster,
  output logic [7:0]           sectors_per_cluster
);
  localparam int CW = $clog2(SECTOR_BYTES + 1);
  localparam int PE = 446 + 16 * PART_INDEX;

  localparam logic [2:0] E_NONE  = 3'd0, E_TMO  = 3'd1, E_MBR  = 3'd2, E_TYPE = 3'd3,
                         E_VBR   = 3'd4, E_BPS  = 3'd5, E_SHORT = 3'd6, E_SPC = 3'd7;

  typedef enum logic [3:0] {
    IDLE, INIT_REQ, INIT_WAIT, MBR_REQ, MBR_READ, MBR_CHECK,
    VBR_REQ, VBR_READ, VBR_CHECK, CALC, DONE, FAIL
  } state_t;

  state_t          state, state_d;
  logic [2:0]      fail_code;
  logic            start, rd_go, byte_stb, timed;
  logic [CW-1:0]   byte_cnt, cnt_next;
  logic [31:0]     tmo_cnt;
  logic            busy_q, init_q, rd_req_q;
  logic [31:0]     addr_q;

  logic [7:0]      part_type, sig0, sig1, spc_q, nfats;
  logic [31:0]     part_lba, fat_size, root_q;
  logic [15:0]     bps, rsvd;
  logic [31:0]     fb_acc, cl_acc;
  logic [7:0]      fat_cnt;

  assign sd.sd_init   = init_q;
  assign sd.sd_rd_req = rd_req_q;
  assign sd.sd_addr   = addr_q;

  always_comb begin
    state_d   = state;
    fail_code = E_NONE;
    start     = 1'b0;
    rd_go     = 1'b0;
    timed     = 1'b0;
    byte_stb  = sd.sd_byte_valid && (byte_cnt < CW'(SECTOR_BYTES));
    cnt_next  = byte_cnt + CW'(byte_stb);
    case (state)
      IDLE, DONE, FAIL: if (execute) begin start = 1'b1; state_d = INIT_REQ; end
      INIT_REQ:  state_d = INIT_WAIT;
      INIT_WAIT: begin
        timed = 1'b1;
        if (busy_q && !sd.sd_busy) state_d = MBR_REQ;
      end
      MBR_REQ, VBR_REQ: begin
        timed = 1'b1;
        if (!sd.sd_busy) begin
          rd_go   = 1'b1;
          state_d = (state == MBR_REQ) ? MBR_READ : VBR_READ;
        end
      end
      MBR_READ, VBR_READ: begin
        timed = 1'b1;
        // A byte arriving with block_done is counted before the length check.
        if (sd.sd_block_done) begin
          if (cnt_next != CW'(SECTOR_BYTES)) begin
            state_d = FAIL; fail_code = E_SHORT;
          end else begin
            state_d = (state == MBR_READ) ? MBR_CHECK : VBR_CHECK;
          end
        end
      end
      MBR_CHECK: begin
        if (sig0 != 8'h55 || sig1 != 8'hAA) begin
          state_d = FAIL; fail_code = E_MBR;
        end else if (part_type != 8'h0B && part_type != 8'h0C) begin
          state_d = FAIL; fail_code = E_TYPE;
        end else begin
          state_d = VBR_REQ;
        end
      end
      VBR_CHECK: begin
        if (sig0 != 8'h55 || sig1 != 8'hAA) begin
          state_d = FAIL; fail_code = E_VBR;
        end else if (bps != 16'(SECTOR_BYTES)) begin
          state_d = FAIL; fail_code = E_BPS;
        end else if (spc_q == 8'd0 || (spc_q & (spc_q - 8'd1)) != 8'd0) begin
          state_d = FAIL; fail_code = E_SPC;
        end else begin
          state_d = CALC;
        end
      end
      CALC:    if (fat_cnt == 8'd0) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (timed && state_d == state && (tmo_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
      state_d   = FAIL;
      fail_code = E_TMO;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; done <= 1'b0; error <= 1'b0; err_code <= E_NONE;
      init_q <= 1'b0; rd_req_q <= 1'b0; addr_q <= '0; busy_q <= 1'b0;
      tmo_cnt <= '0; byte_cnt <= '0;
      fat_begin_lba <= '0; cluster_begin_lba <= '0; root_cluster <= '0; sectors_per_cluster <= '0;
      part_type <= '0; part_lba <= '0; sig0 <= '0; sig1 <= '0;
      bps <= '0; spc_q <= '0; rsvd <= '0; nfats <= '0; fat_size <= '0; root_q <= '0;
      fb_acc <= '0; cl_acc <= '0; fat_cnt <= '0;
    end else begin
      busy     <= !(state_d inside {IDLE, DONE, FAIL});
      done     <= (state == CALC) && (state_d == DONE);
      error    <= (state_d == FAIL);
      init_q   <= (state == INIT_REQ);
      rd_req_q <= rd_go;
      busy_q   <= sd.sd_busy;
      tmo_cnt  <= (state_d != state) ? 32'd0 : (timed ? tmo_cnt + 32'd1 : tmo_cnt);

      if (start) begin
        err_code <= E_NONE; addr_q <= '0;
        fat_begin_lba <= '0; cluster_begin_lba <= '0; root_cluster <= '0; sectors_per_cluster <= '0;
      end
      if (state_d == FAIL && state != FAIL) begin
        err_code <= fail_code;
        fat_begin_lba <= '0; cluster_begin_lba <= '0; root_cluster <= '0; sectors_per_cluster <= '0;
      end

      if (rd_go) begin
        addr_q   <= (state == VBR_REQ) ? part_lba : 32'd0;
        byte_cnt <= '0;
      end else if (state == MBR_READ || state == VBR_READ) begin
        byte_cnt <= cnt_next;
      end

      if ((state == MBR_READ || state == VBR_READ) && byte_stb) begin
        if (byte_cnt == CW'(510)) sig0 <= sd.sd_byte;
        if (byte_cnt == CW'(511)) sig1 <= sd.sd_byte;
      end
      if (state == MBR_READ && byte_stb) begin
        if (byte_cnt == CW'(PE + 4)) part_type <= sd.sd_byte;
        for (int b = 0; b < 4; b++)
          if (byte_cnt == CW'(PE + 8 + b)) part_lba[8*b +: 8] <= sd.sd_byte;
      end
      if (state == VBR_READ && byte_stb) begin
        if (byte_cnt == CW'(13)) spc_q <= sd.sd_byte;
        if (byte_cnt == CW'(16)) nfats <= sd.sd_byte;
        for (int b = 0; b < 2; b++) begin
          if (byte_cnt == CW'(11 + b)) bps[8*b +: 8]  <= sd.sd_byte;
          if (byte_cnt == CW'(14 + b)) rsvd[8*b +: 8] <= sd.sd_byte;
        end
        for (int b = 0; b < 4; b++) begin
          if (byte_cnt == CW'(36 + b)) fat_size[8*b +: 8] <= sd.sd_byte;
          if (byte_cnt == CW'(44 + b)) root_q[8*b +: 8]   <= sd.sd_byte;
        end
      end

      // cluster_begin accumulates one FAT copy per CALC cycle instead of a multiplier.
      if (state == VBR_CHECK) begin
        fb_acc  <= part_lba + {16'd0, rsvd};
        cl_acc  <= part_lba + {16'd0, rsvd};
        fat_cnt <= nfats;
      end else if (state == CALC && fat_cnt != 8'd0) begin
        cl_acc  <= cl_acc + fat_size;
        fat_cnt <= fat_cnt - 8'd1;
      end
      if (state == CALC && state_d == DONE) begin
        fat_begin_lba       <= fb_acc;
        cluster_begin_lba   <= cl_acc;
        root_cluster        <= root_q;
        sectors_per_cluster <= spc_q;
      end
    end
  end
endmodule

// File: tb/tb_fat32_volume_mount.sv
// Directed bench: u0 default, u1 PART_INDEX=2, u2 TIMEOUT_CYCLES=100; shared SD stimulus.
`timescale 1ns/1ps
module tb_fat32_volume_mount;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] exe;
  logic [7:0] sd_byte;
  logic       sd_byte_valid, sd_block_done, sd_busy;

  logic        busy_w [3];
  logic        done_w [3];
  logic        err_w  [3];
  logic [2:0]  ec_w   [3];
  logic [31:0] fb_w   [3];
  logic [31:0] cb_w   [3];
  logic [31:0] rc_w   [3];
  logic [7:0]  spc_w  [3];

  logic [7:0] img [512];
  int n_pass = 0, n_fail = 0, n_tot = 0;

  fat32_volume_mount_if sif0 ();
  fat32_volume_mount_if sif1 ();
  fat32_volume_mount_if sif2 ();
  assign sif0.sd_byte = sd_byte; assign sif0.sd_byte_valid = sd_byte_valid;
  assign sif0.sd_block_done = sd_block_done; assign sif0.sd_busy = sd_busy;
  assign sif1.sd_byte = sd_byte; assign sif1.sd_byte_valid = sd_byte_valid;
  assign sif1.sd_block_done = sd_block_done; assign sif1.sd_busy = sd_busy;
  assign sif2.sd_byte = sd_byte; assign sif2.sd_byte_valid = sd_byte_valid;
  assign sif2.sd_block_done = sd_block_done; assign sif2.sd_busy = sd_busy;

  fat32_volume_mount u0 (
    .clk(clk), .rst_n(rst_n), .execute(exe[0]), .sd(sif0),
    .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0]), .err_code(ec_w[0]),
    .fat_begin_lba(fb_w[0]), .cluster_begin_lba(cb_w[0]), .root_cluster(rc_w[0]),
    .sectors_per_cluster(spc_w[0]));
  fat32_volume_mount #(.PART_INDEX(2)) u1 (
    .clk(clk), .rst_n(rst_n), .execute(exe[1]), .sd(sif1),
    .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1]), .err_code(ec_w[1]),
    .fat_begin_lba(fb_w[1]), .cluster_begin_lba(cb_w[1]), .root_cluster(rc_w[1]),
    .sectors_per_cluster(spc_w[1]));
  fat32_volume_mount #(.TIMEOUT_CYCLES(100)) u2 (
    .clk(clk), .rst_n(rst_n), .execute(exe[2]), .sd(sif2),
    .busy(busy_w[2]), .done(done_w[2]), .error(err_w[2]), .err_code(ec_w[2]),
    .fat_begin_lba(fb_w[2]), .cluster_begin_lba(cb_w[2]), .root_cluster(rc_w[2]),
    .sectors_per_cluster(spc_w[2]));

  // s: 0 sd_init, 1 sd_rd_req, 2 done, 3 error
  function automatic logic probe(input int k, input int s);
    logic [3:0] v;
    case (k)
      0:       v = {sif0.sd_init, sif0.sd_rd_req, done_w[0], err_w[0]};
      1:       v = {sif1.sd_init, sif1.sd_rd_req, done_w[1], err_w[1]};
      2:       v = {sif2.sd_init, sif2.sd_rd_req, done_w[2], err_w[2]};
      default: v = 4'd0;
    endcase
    return v[3-s];
  endfunction

  function automatic logic [31:0] addr_of(input int k);
    case (k)
      0:       return sif0.sd_addr;
      1:       return sif1.sd_addr;
      default: return sif2.sd_addr;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mk_mbr(input int idx, input logic [7:0] ptype, input logic [31:0] lba,
                        input logic [7:0] s511);
    foreach (img[i]) img[i] = 8'h00;
    img[446+16*idx+4] = ptype;
    for (int b = 0; b < 4; b++) img[446+16*idx+8+b] = lba[8*b +: 8];
    img[510] = 8'h55; img[511] = s511;
  endtask

  task automatic mk_vbr(input logic [15:0] bps, input logic [7:0] spc, input logic [7:0] nf,
                        input logic [7:0] s511);
    logic [31:0] fsz, root;
    fsz = 32'h0000_03C1; root = 32'd2;
    foreach (img[i]) img[i] = 8'h00;
    img[11] = bps[7:0]; img[12] = bps[15:8]; img[13] = spc;
    img[14] = 8'd32;    img[15] = 8'd0;      img[16] = nf;
    for (int b = 0; b < 4; b++) begin
      img[36+b] = fsz[8*b +: 8];
      img[44+b] = root[8*b +: 8];
    end
    img[510] = 8'h55; img[511] = s511;
  endtask

  // Back-to-back bytes, block_done alongside the last byte; rst_at >= 0 pulls reset instead.
  task automatic send_block(input int n, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (i == rst_at) begin
        rst_n = 1'b0; sd_byte_valid = 1'b0; sd_block_done = 1'b0;
        return;
      end
      sd_byte = img[i]; sd_byte_valid = 1'b1; sd_block_done = (i == n - 1);
    end
    @(posedge clk);
    sd_byte_valid = 1'b0; sd_block_done = 1'b0;
  endtask

  task automatic wait_for(input int k, input int s, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      seen = probe(k, s);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic start(input int k);
    @(posedge clk); exe[k] = 1'b1;
    @(posedge clk); exe[k] = 1'b0;
    chk("busy_on_start", 32'(busy_w[k]), 32'd1);
  endtask

  task automatic front(input int k);
    start(k);
    wait_for(k, 0, 10, "sd_init");
    sd_busy = 1'b1;
    repeat (3) @(posedge clk);
    sd_busy = 1'b0;
    wait_for(k, 1, 20, "mbr_req");
    chk("mbr_addr", addr_of(k), 32'd0);
  endtask

  task automatic mbr_ok(input int k, input int idx, input logic [31:0] lba);
    mk_mbr(idx, 8'h0C, lba, 8'hAA);
    send_block(512, -1);
    wait_for(k, 1, 20, "vbr_req");
    chk("vbr_addr", addr_of(k), lba);
  endtask

  task automatic mount_ok(input int k, input int idx, input logic [31:0] lba,
                          input logic [7:0] nf, input logic [31:0] exp_cb);
    front(k);
    mbr_ok(k, idx, lba);
    mk_vbr(16'd512, 8'd8, nf, 8'hAA);
    send_block(512, -1);
    wait_for(k, 2, 20, "done");
    chk("fat_begin", fb_w[k], lba + 32'd32);
    chk("cluster_begin", cb_w[k], exp_cb);
    chk("root_cluster", rc_w[k], 32'd2);
    chk("spc", 32'(spc_w[k]), 32'd8);
    chk("ok_code", 32'(ec_w[k]), 32'd0);
    chk("ok_busy", 32'(busy_w[k]), 32'd0);
    chk("ok_error", 32'(err_w[k]), 32'd0);
    @(posedge clk);
    chk("done_one_cycle", 32'(done_w[k]), 32'd0);
    chk("cb_held", cb_w[k], exp_cb);
  endtask

  task automatic expect_fail(input int k, input logic [2:0] code, input string tag);
    bit seen, req;
    seen = 1'b0; req = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      seen = probe(k, 3);
      req  = req | probe(k, 1);
    end
    chk({tag, "_error"}, 32'(seen), 32'd1);
    chk({tag, "_code"}, 32'(ec_w[k]), 32'(code));
    chk({tag, "_busy"}, 32'(busy_w[k]), 32'd0);
    chk({tag, "_fb_zero"}, fb_w[k], 32'd0);
    chk({tag, "_no_req"}, 32'(req), 32'd0);
  endtask

  initial begin
    bit stray;
    rst_n = 1'b0; exe = '0; sd_byte = '0;
    sd_byte_valid = 1'b0; sd_block_done = 1'b0; sd_busy = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_error", 32'(err_w[0]), 32'd0);
    chk("rst_code", 32'(ec_w[0]), 32'd0);
    chk("rst_init", 32'(sif0.sd_init), 32'd0);
    chk("rst_rdreq", 32'(sif0.sd_rd_req), 32'd0);
    chk("rst_addr", sif0.sd_addr, 32'd0);
    chk("rst_fb", fb_w[0], 32'd0);
    chk("rst_cb", cb_w[0], 32'd0);
    chk("rst_spc", 32'(spc_w[0]), 32'd0);
    rst_n = 1'b1;

    // 0x820 + 2*0x3C1 = 0xFA2
    mount_ok(0, 0, 32'h0000_0800, 8'd2, 32'h0000_0FA2);
    // Zero FAT copies: cluster region starts right at the FAT.
    mount_ok(0, 0, 32'h0000_0800, 8'd0, 32'h0000_0820);

    front(0);
    mk_mbr(0, 8'h0C, 32'h0000_0800, 8'h00);
    send_block(512, -1);
    expect_fail(0, 3'd2, "mbr_sig");

    front(0);
    mk_mbr(0, 8'h0C, 32'h0000_0800, 8'hAA);
    send_block(300, -1);
    expect_fail(0, 3'd6, "short");

    front(0); mbr_ok(0, 0, 32'h0000_0800);
    mk_vbr(16'd512, 8'd6, 8'd2, 8'hAA); send_block(512, -1);
    expect_fail(0, 3'd7, "spc6");

    front(0); mbr_ok(0, 0, 32'h0000_0800);
    mk_vbr(16'd4096, 8'd8, 8'd2, 8'hAA); send_block(512, -1);
    expect_fail(0, 3'd5, "bps");

    // Bad signature outranks bad bytes/sector.
    front(0); mbr_ok(0, 0, 32'h0000_0800);
    mk_vbr(16'd4096, 8'd8, 8'd2, 8'h00); send_block(512, -1);
    expect_fail(0, 3'd4, "vbr_sig");

    front(1);
    mk_mbr(2, 8'h07, 32'h0000_1000, 8'hAA);
    send_block(512, -1);
    expect_fail(1, 3'd3, "ptype");
    // 0x1020 + 2*0x3C1 = 0x17A2
    mount_ok(1, 2, 32'h0000_1000, 8'd2, 32'h0000_17A2);

    start(2);
    wait_for(2, 0, 10, "tmo_init");
    sd_busy = 1'b1;
    repeat (99) @(negedge clk);
    @(posedge clk);
    chk("tmo_not_yet", 32'(err_w[2]), 32'd0);
    @(posedge clk);
    chk("tmo_error", 32'(err_w[2]), 32'd1);
    chk("tmo_code", 32'(ec_w[2]), 32'd1);
    chk("tmo_busy", 32'(busy_w[2]), 32'd0);
    sd_busy = 1'b0;

    front(0); mbr_ok(0, 0, 32'h0000_0800);
    mk_vbr(16'd512, 8'd8, 8'd2, 8'hAA);
    send_block(512, 200);
    #1;
    chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_rst_addr", sif0.sd_addr, 32'd0);
    chk("mid_rst_code", 32'(ec_w[0]), 32'd0);
    chk("mid_rst_error", 32'(err_w[0]), 32'd0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (30) begin
      @(posedge clk);
      stray = stray | probe(0, 0) | probe(0, 1);
    end
    chk("no_req_after_rst", 32'(stray), 32'd0);
    mount_ok(0, 0, 32'h0000_0800, 8'd2, 32'h0000_0FA2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
